// File: rtl/axis_pbk_src.sv
// AXIS playback source: host preloads a sample buffer in IDLE, then the block streams it
// as an AXIS master with tlast framing, optional frame count limit and graceful stop.
module axis_pbk_src #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned DEPTH      = 64,
  parameter int unsigned FRAME_LEN  = DEPTH,
  parameter int unsigned NUM_FRAMES = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     start,
  input  logic                     stop,
  output logic [WIDTH-1:0]         m_axis_tdata,
  output logic                     m_axis_tvalid,
  input  logic                     m_axis_tready,
  output logic                     m_axis_tlast,
  output logic                     busy,
  output logic                     done,
  output logic                     wr_err,
  output logic [15:0]              frame_cnt
);

  localparam int unsigned        IW       = $clog2(DEPTH);
  localparam logic [IW-1:0]      LAST_IDX = IW'(FRAME_LEN - 1);
  localparam logic [15:0]        NF       = 16'(NUM_FRAMES);
  localparam bit                 FINITE   = (NUM_FRAMES != 0);

  typedef enum logic [1:0] {
    IDLE,
    PRIME,
    STREAM,
    DONE
  } state_t;

  state_t            state_q, state_d;
  logic [IW-1:0]     idx_q, idx_d, idx_nxt;
  logic [15:0]       fcnt_q, fcnt_d;
  logic              stop_pend_q, stop_pend_d;
  logic              wr_err_q, wr_err_d;
  logic [WIDTH-1:0]  rdata_q;
  logic              rd_en;
  logic [IW-1:0]     rd_addr;
  logic              xfer;
  logic              at_last;

  logic [WIDTH-1:0]  mem [DEPTH];

  assign at_last = (idx_q == LAST_IDX);
  assign idx_nxt = at_last ? '0 : idx_q + IW'(1);
  assign xfer    = (state_q == STREAM) && m_axis_tready;

  always_ff @(posedge clk) begin
    if (wr_en && (state_q == IDLE)) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // The read-data register doubles as the output register: it is only reloaded on a
  // transfer (or in PRIME), so tdata holds under backpressure and the next sample is
  // already being fetched during the beat that consumes the current one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else if (rd_en) begin
      rdata_q <= mem[rd_addr];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      fcnt_q      <= '0;
      stop_pend_q <= 1'b0;
      wr_err_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      fcnt_q      <= fcnt_d;
      stop_pend_q <= stop_pend_d;
      wr_err_q    <= wr_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    fcnt_d      = fcnt_q;
    stop_pend_d = stop_pend_q;
    wr_err_d    = wr_en && (state_q != IDLE);
    rd_en       = 1'b0;
    rd_addr     = idx_nxt;
    unique case (state_q)
      IDLE: begin
        stop_pend_d = 1'b0;
        if (start) state_d = PRIME;
      end
      PRIME: begin
        idx_d   = '0;
        fcnt_d  = '0;
        rd_en   = 1'b1;
        rd_addr = '0;
        if (stop) stop_pend_d = 1'b1;
        state_d = STREAM;
      end
      STREAM: begin
        if (stop) stop_pend_d = 1'b1;
        if (xfer) begin
          idx_d = idx_nxt;
          rd_en = 1'b1;
          if (at_last) begin
            fcnt_d = fcnt_q + 16'd1;
            if ((FINITE && (fcnt_q + 16'd1 == NF)) || stop_pend_q || stop) begin
              state_d = DONE;
            end
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign m_axis_tdata  = rdata_q;
  assign m_axis_tvalid = (state_q == STREAM);
  assign m_axis_tlast  = (state_q == STREAM) && at_last;
  assign busy          = (state_q == PRIME) || (state_q == STREAM);
  assign done          = (state_q == DONE);
  assign wr_err        = wr_err_q;
  assign frame_cnt     = fcnt_q;

endmodule

// File: tb/tb_axis_pbk_src.sv
// Directed bench for axis_pbk_src: three instances with different framing parameters,
// beats checked against a queue of expected {tlast, tdata} pushed when playback is set up.
module tb_axis_pbk_src;
  localparam int W  = 32;
  localparam int AW = 6;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic [2:0]    wr_en = '0, start = '0, stop = '0, tready = '0;
  logic [2:0]    tvalid, tlast, busy, done, wr_err;
  logic [AW-1:0] wr_addr [3];
  logic [W-1:0]  wr_data [3];
  logic [W-1:0]  tdata   [3];
  logic [15:0]   fcnt    [3];

  axis_pbk_src #(.WIDTH(W), .DEPTH(64), .FRAME_LEN(64), .NUM_FRAMES(2)) u0 (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en[0]), .wr_addr(wr_addr[0]), .wr_data(wr_data[0]),
    .start(start[0]), .stop(stop[0]), .m_axis_tdata(tdata[0]), .m_axis_tvalid(tvalid[0]),
    .m_axis_tready(tready[0]), .m_axis_tlast(tlast[0]), .busy(busy[0]), .done(done[0]),
    .wr_err(wr_err[0]), .frame_cnt(fcnt[0]));

  axis_pbk_src #(.WIDTH(W), .DEPTH(64), .FRAME_LEN(48), .NUM_FRAMES(0)) u1 (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en[1]), .wr_addr(wr_addr[1]), .wr_data(wr_data[1]),
    .start(start[1]), .stop(stop[1]), .m_axis_tdata(tdata[1]), .m_axis_tvalid(tvalid[1]),
    .m_axis_tready(tready[1]), .m_axis_tlast(tlast[1]), .busy(busy[1]), .done(done[1]),
    .wr_err(wr_err[1]), .frame_cnt(fcnt[1]));

  axis_pbk_src #(.WIDTH(W), .DEPTH(64), .FRAME_LEN(1), .NUM_FRAMES(0)) u2 (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en[2]), .wr_addr(wr_addr[2]), .wr_data(wr_data[2]),
    .start(start[2]), .stop(stop[2]), .m_axis_tdata(tdata[2]), .m_axis_tvalid(tvalid[2]),
    .m_axis_tready(tready[2]), .m_axis_tlast(tlast[2]), .busy(busy[2]), .done(done[2]),
    .wr_err(wr_err[2]), .frame_cnt(fcnt[2]));

  logic [W:0]  exp_q [$];
  int unsigned n_cmp = 0, n_err = 0;
  int          d = 0;
  int          beats = 0, cyc = 0, last_xfer = 0;
  bit          hold_v = 0, done_seen = 0, busy_s = 0, rnd = 0;
  logic [W-1:0] hold_d;
  logic         hold_l;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Sample on the falling edge, then advance past the next rising edge.
  task automatic tick();
    @(negedge clk);
    cyc++;
    done_seen = done[d];
    busy_s    = busy[d];
    if (hold_v) begin
      chk("hold_tvalid", tvalid[d], 1'b1);
      chk("hold_tdata", tdata[d], hold_d);
      chk("hold_tlast", tlast[d], hold_l);
    end
    if (tvalid[d] && tready[d]) begin
      chk("beat_expected", exp_q.size() != 0, 1'b1);
      if (exp_q.size() != 0) chk($sformatf("beat%0d", beats), {tlast[d], tdata[d]}, exp_q.pop_front());
      beats++;
      last_xfer = cyc;
    end
    hold_v = tvalid[d] && !tready[d];
    hold_d = tdata[d];
    hold_l = tlast[d];
    @(posedge clk);
    #1;
    if (rnd) tready[d] = 1'($urandom_range(0, 1));
  endtask

  task automatic load(input int base, input int n);
    for (int i = 0; i < n; i++) begin
      wr_en[d] = 1'b1; wr_addr[d] = AW'(i); wr_data[d] = W'(base + i);
      tick();
    end
    wr_en[d] = 1'b0;
  endtask

  task automatic push_frames(input int base, input int fl, input int nf);
    for (int f = 0; f < nf; f++)
      for (int i = 0; i < fl; i++) exp_q.push_back({i == fl - 1, W'(base + i)});
  endtask

  task automatic do_start();
    start[d] = 1'b1;
    tick();
    start[d] = 1'b0;
    beats = 0;
    hold_v = 0;
  endtask

  task automatic run_to(input int n, input int max);
    for (int i = 0; i < max && beats < n; i++) tick();
    chk("beats_reached", beats >= n, 1'b1);
  endtask

  task automatic run_done(input int max, input logic [15:0] efc);
    done_seen = 0;
    for (int i = 0; i < max && !done_seen; i++) tick();
    chk("done_seen", done_seen, 1'b1);
    chk("done_gap", cyc - last_xfer, 1);
    chk("busy_at_done", busy_s, 1'b0);
    chk("queue_empty", exp_q.size(), 0);
    chk("frame_cnt", fcnt[d], efc);
    tick();
    chk("done_one_cycle", done_seen, 1'b0);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin wr_addr[i] = '0; wr_data[i] = '0; end
    #2 rst_n = 1'b0;
    tick();
    chk("rst_tvalid", tvalid, 3'b000);
    chk("rst_tlast", tlast, 3'b000);
    chk("rst_tdata", tdata[0], 0);
    chk("rst_busy", busy, 3'b000);
    chk("rst_done", done, 3'b000);
    chk("rst_wr_err", wr_err, 3'b000);
    chk("rst_fcnt", fcnt[0], 0);
    rst_n = 1'b1;
    tick();

    // Two full frames, no backpressure
    d = 0;
    load(32'h100, 64);
    tready[0] = 1'b1;
    push_frames(32'h100, 64, 2);
    do_start();
    chk("prime_tvalid", tvalid[0], 1'b0);
    chk("prime_busy", busy[0], 1'b1);
    tick();
    chk("first_tvalid", tvalid[0], 1'b1);
    chk("first_tdata", tdata[0], 32'h100);
    chk("first_fcnt", fcnt[0], 0);
    run_done(400, 16'd2);

    // Same playback under random backpressure
    rnd = 1;
    tready[0] = 1'($urandom_range(0, 1));
    push_frames(32'h100, 64, 2);
    do_start();
    run_done(2000, 16'd2);
    rnd = 0;

    // FRAME_LEN=48, loop until stop; dropped write while streaming
    d = 1;
    load(32'h200, 64);
    tready[1] = 1'b1;
    push_frames(32'h200, 48, 3);
    do_start();
    run_to(20, 200);
    wr_en[1] = 1'b1; wr_addr[1] = AW'(5); wr_data[1] = 32'hDEAD_BEEF;
    tick();
    wr_en[1] = 1'b0;
    chk("wr_err_pulse", wr_err[1], 1'b1);
    tick();
    chk("wr_err_clear", wr_err[1], 1'b0);
    run_to(106, 300);
    stop[1] = 1'b1;
    tick();
    stop[1] = 1'b0;
    run_done(200, 16'd3);

    // Replay shows original word at addr 5; stop during PRIME ends after one frame
    rnd = 1;
    push_frames(32'h200, 48, 1);
    do_start();
    stop[1] = 1'b1;
    tick();
    stop[1] = 1'b0;
    run_done(1000, 16'd1);
    rnd = 0;

    // Async reset mid-frame under backpressure, then a clean replay
    d = 0;
    tready[0] = 1'b1;
    push_frames(32'h100, 64, 2);
    do_start();
    run_to(70, 300);
    tready[0] = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    chk("async_tvalid", tvalid[0], 1'b0);
    chk("async_busy", busy[0], 1'b0);
    chk("async_fcnt", fcnt[0], 0);
    chk("async_tdata", tdata[0], 0);
    exp_q.delete();
    hold_v = 0;
    tick();
    rst_n = 1'b1;
    tick();
    tready[0] = 1'b1;
    push_frames(32'h100, 64, 2);
    do_start();
    tick();
    chk("replay_tdata", tdata[0], 32'h100);
    chk("replay_fcnt", fcnt[0], 0);
    run_done(400, 16'd2);

    // FRAME_LEN=1: every beat is a frame; start while busy is ignored
    d = 2;
    load(32'h3AA, 1);
    push_frames(32'h3AA, 1, 10);
    rnd = 1;
    tready[2] = 1'($urandom_range(0, 1));
    do_start();
    run_to(3, 200);
    start[2] = 1'b1;
    tick();
    start[2] = 1'b0;
    chk("restart_busy", busy[2], 1'b1);
    chk("restart_fcnt", fcnt[2], beats);
    run_to(9, 200);
    rnd = 0;
    tready[2] = 1'b1;
    stop[2] = 1'b1;
    tick();
    stop[2] = 1'b0;
    run_done(20, 16'd10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
